wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning write-back data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning architectural register index width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning contention counter width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  3  per-requester write-back request; bit0 ALU, bit1 MUL, bit2 LSU.
REQ-007 SHALL have port req_rd  input  3*ADDR_W  per-requester destination index; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port req_data  input  3*DATA_W  per-requester result; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port req_ready  output  3  per-requester accept; a request transfers in any cycle where req_valid[i] and req_ready[i] are both 1.
REQ-010 SHALL have port flush  input  1  discards the output stage and restores the priority pointer.
REQ-011 SHALL have port addr_p2  output  ADDR_W  register-file write address.
REQ-012 SHALL have port we_p2  output  1  register-file write enable.
REQ-013 SHALL have port din_p2  output  DATA_W  register-file write data.
REQ-014 SHALL have port contention_cnt  output  CNT_W  saturating count of cycles with two or more valid requesters.
REQ-015 SHALL have port grant_id  output  2  index of the requester that sourced the current output stage (0..2).

Function
REQ-016 SHALL grant at most one requester per cycle; req_ready SHALL be one-hot or zero and SHALL depend combinationally on req_valid and the pointer only.
REQ-017 SHALL use round-robin arbitration: search order is ptr, ptr+1, ptr+2 (mod 3); the first requester in that order with req_valid=1 is granted.
REQ-018 SHALL, on a grant to requester g, update ptr to (g+1) mod 3 on the next edge; with no grant, ptr SHALL hold.
REQ-019 SHALL capture the granted rd and data into a registered output stage; addr_p2/din_p2/we_p2 SHALL reflect the transfer exactly one cycle after the handshake.
REQ-020 SHALL set we_p2=1 for a captured transfer only if the captured rd != 0; for rd == 0 the handshake SHALL complete, addr_p2/din_p2 SHALL update, and we_p2 SHALL be 0.
REQ-021 SHALL set we_p2=0 in any cycle following a cycle with no grant.
REQ-022 SHALL sustain one write-back per cycle; the output stage never back-pressures because the register-file write port always accepts.
REQ-023 SHALL bound the wait of a continuously valid requester to at most 2 cycles before its grant.
REQ-024 SHALL, when flush=1, deassert all req_ready in that cycle, set we_p2=0 on the next edge, and set ptr=0 on the next edge.
REQ-025 SHALL increment contention_cnt on each edge where flush=0 and popcount(req_valid) >= 2, saturating at 2^CNT_W-1 with no wrap.
REQ-026 SHALL keep grant_id equal to the index captured with the current output stage; grant_id SHALL hold when there is no grant.
REQ-027 SHALL preserve acceptance order for successive writes to the same rd; the register file SHALL see them in the cycle order in which they were granted.

Reset
REQ-028 SHALL, while reset=1, drive req_ready=0 combinationally and, on the edge, set we_p2=0, addr_p2=0, din_p2=0, grant_id=0, ptr=0, contention_cnt=0.
REQ-029 SHALL give reset priority over flush and over any request; a request presented during reset SHALL NOT be accepted.
REQ-030 SHALL accept a request presented in the first cycle after reset deasserts, with ptr=0.

Verification
REQ-031 SHALL be verified with: after reset, req_valid=3'b001, rd=5, data=0xDEADBEEF for 1 cycle -> req_ready=3'b001; next cycle we_p2=1, addr_p2=5, din_p2=0xDEADBEEF, grant_id=0.
REQ-032 SHALL be verified with: req_valid=3'b111 held for 6 cycles -> grants in order 0,1,2,0,1,2; contention_cnt=6.
REQ-033 SHALL be verified with: grant to ALU with rd=0, data=0x12345678 -> req_ready[0]=1; next cycle we_p2=0, addr_p2=0, din_p2=0x12345678.
REQ-034 SHALL be verified with: req_valid=3'b110 granted MUL, then flush=1 with req_valid=3'b111 -> req_ready=0 in the flush cycle; next cycle we_p2=0; following cycle the grant goes to ALU (ptr=0).
REQ-035 SHALL be verified with: CNT_W=4 and req_valid=3'b011 for 20 cycles -> contention_cnt saturates and holds at 15.
REQ-036 SHALL be verified with: reset asserted while req_valid=3'b100 -> req_ready=0 and we_p2=0 throughout reset; in the first cycle after release req_ready=3'b100.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Three-requester (ALU/MUL/LSU) round-robin write-back arbiter feeding one
// registered register-file write port, plus a saturating contention counter.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req_valid,
  input  logic [3*ADDR_W-1:0]   req_rd,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            req_ready,
  input  logic                  flush,
  output logic [ADDR_W-1:0]     addr_p2,
  output logic                  we_p2,
  output logic [DATA_W-1:0]     din_p2,
  output logic [CNT_W-1:0]      contention_cnt,
  output logic [1:0]            grant_id
);

  logic [1:0]              r_ptr;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_din;
  logic                    r_we;
  logic [1:0]              r_gid;
  logic [CNT_W-1:0]        r_cnt;

  logic [2:0][ADDR_W-1:0]  w_rd_a;
  logic [2:0][DATA_W-1:0]  w_data_a;
  logic [2:0]              w_sum;
  logic [1:0]              w_cand;
  logic                    w_gnt;
  logic [1:0]              w_gnt_idx;
  logic [1:0]              w_ptr_nxt;
  logic                    w_multi;
  logic [ADDR_W-1:0]       w_rd;

  assign w_rd_a   = req_rd;
  assign w_data_a = req_data;
  assign w_rd     = w_rd_a[w_gnt_idx];
  assign w_multi  = (req_valid[0] & req_valid[1]) | (req_valid[0] & req_valid[2]) |
                    (req_valid[1] & req_valid[2]);
  assign w_ptr_nxt = (w_gnt_idx == 2'd2) ? 2'd0 : w_gnt_idx + 2'd1;

  // Search ptr, ptr+1, ptr+2 (mod 3); reset and flush suppress every grant.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = r_ptr;
    w_sum     = '0;
    w_cand    = '0;
    req_ready = '0;
    if (!reset && !flush) begin
      for (int k = 0; k < 3; k++) begin
        w_sum  = {1'b0, r_ptr} + 3'(k);
        w_cand = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
        if (!w_gnt && req_valid[w_cand]) begin
          w_gnt     = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
      if (w_gnt) req_ready = 3'b001 << w_gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= '0;
      r_addr <= '0;
      r_din  <= '0;
      r_we   <= 1'b0;
      r_gid  <= '0;
      r_cnt  <= '0;
    end else begin
      if (!flush && w_multi && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
      if (flush) begin
        r_we  <= 1'b0;
        r_ptr <= '0;
      end else if (w_gnt) begin
        r_addr <= w_rd;
        r_din  <= w_data_a[w_gnt_idx];
        r_we   <= |w_rd;  // x0 writes complete the handshake but never commit
        r_gid  <= w_gnt_idx;
        r_ptr  <= w_ptr_nxt;
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign addr_p2        = r_addr;
  assign din_p2         = r_din;
  assign we_p2          = r_we;
  assign grant_id       = r_gid;
  assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: driver pushes model expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               flush = 1'b0;
  logic [2:0]         req_valid = '0;
  logic [3*AW-1:0]    req_rd = '0;
  logic [3*DW-1:0]    req_data = '0;
  logic [2:0]         req_ready, u4_ready;
  logic [AW-1:0]      addr_p2, u4_addr;
  logic               we_p2, u4_we;
  logic [DW-1:0]      din_p2, u4_din;
  logic [15:0]        contention_cnt;
  logic [3:0]         u4_cnt;
  logic [1:0]         grant_id, u4_gid;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready), .flush(flush),
    .addr_p2(addr_p2), .we_p2(we_p2), .din_p2(din_p2),
    .contention_cnt(contention_cnt), .grant_id(grant_id));

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(u4_ready), .flush(flush),
    .addr_p2(u4_addr), .we_p2(u4_we), .din_p2(u4_din),
    .contention_cnt(u4_cnt), .grant_id(u4_gid));

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [1:0]    gid;
    int            cnt;
    int            cnt4;
  } out_t;

  logic [2:0] rdy_q[$];
  out_t       out_q[$];

  int n_chk = 0, n_pass = 0;

  // Reference model state (values the DUT should show after the next edge)
  int            m_ptr = 0, m_cnt = 0, m_cnt4 = 0;
  logic          m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;
  logic [1:0]    m_gid = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
  endtask

  task automatic cyc(input bit rst, input bit fl, input logic [2:0] v,
                     input logic [2:0][AW-1:0] rd, input logic [2:0][DW-1:0] d);
    int   g, pc;
    logic [2:0] er;
    out_t o;
    @(posedge clk);
    #1;
    reset = rst; flush = fl; req_valid = v; req_rd = rd; req_data = d;
    g = -1;
    er = '0;
    if (!rst && !fl)
      for (int k = 0; k < 3; k++)
        if (g < 0 && v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
    if (g >= 0) er[g] = 1'b1;
    pc = int'(v[0]) + int'(v[1]) + int'(v[2]);
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_cnt4 = 0; m_we = 0; m_addr = '0; m_din = '0; m_gid = '0;
    end else begin
      if (!fl && pc >= 2) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (fl) begin
        m_we = 0; m_ptr = 0;
      end else if (g >= 0) begin
        m_addr = rd[g]; m_din = d[g]; m_we = (rd[g] != 0); m_gid = 2'(g);
        m_ptr = (g + 1) % 3;
      end else m_we = 0;
    end
    o.we = m_we; o.addr = m_addr; o.din = m_din; o.gid = m_gid;
    o.cnt = m_cnt; o.cnt4 = m_cnt4;
    rdy_q.push_back(er);
    out_q.push_back(o);
  endtask

  // Monitor: ready is checked in the cycle it is driven; registered outputs
  // are checked one cycle later against the entry held from the previous pass.
  initial begin
    out_t prev;
    bit   have_prev = 0;
    logic [2:0] er;
    forever begin
      @(negedge clk);
      if (have_prev) begin
        chk("we_p2", 64'(we_p2), 64'(prev.we));
        chk("addr_p2", 64'(addr_p2), 64'(prev.addr));
        chk("din_p2", 64'(din_p2), 64'(prev.din));
        chk("grant_id", 64'(grant_id), 64'(prev.gid));
        chk("contention_cnt", 64'(contention_cnt), 64'(prev.cnt));
        chk("contention_cnt_w4", 64'(u4_cnt), 64'(prev.cnt4));
      end
      have_prev = 0;
      if (rdy_q.size() > 0) begin
        er = rdy_q.pop_front();
        chk("req_ready", 64'(req_ready), 64'(er));
      end
      if (out_q.size() > 0) begin
        prev = out_q.pop_front();
        have_prev = 1;
      end
    end
  end

  initial begin
    logic [2:0][AW-1:0] rz;
    logic [2:0][DW-1:0] dz;
    rz = '0; dz = '0;
    // request held through reset is not accepted until release
    cyc(1, 0, 3'b100, {5'd7, 5'd0, 5'd0}, {32'hA5A5_0001, 32'h0, 32'h0});
    cyc(1, 0, 3'b100, {5'd7, 5'd0, 5'd0}, {32'hA5A5_0001, 32'h0, 32'h0});
    cyc(0, 0, 3'b100, {5'd7, 5'd0, 5'd0}, {32'hA5A5_0001, 32'h0, 32'h0});
    cyc(1, 0, 3'b000, rz, dz);
    cyc(0, 0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEAD_BEEF});
    cyc(0, 0, 3'b000, rz, dz);
    // full contention rotation
    cyc(1, 0, 3'b000, rz, dz);
    repeat (6) cyc(0, 0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11});
    cyc(0, 0, 3'b000, rz, dz);
    // rd = 0 handshake, no write
    cyc(0, 0, 3'b001, rz, {32'h0, 32'h0, 32'h1234_5678});
    // flush restores ptr to ALU
    cyc(0, 0, 3'b110, {5'd9, 5'd8, 5'd4}, {32'h99, 32'h88, 32'h44});
    cyc(0, 1, 3'b111, {5'd9, 5'd8, 5'd4}, {32'h99, 32'h88, 32'h44});
    cyc(0, 0, 3'b111, {5'd9, 5'd8, 5'd4}, {32'h99, 32'h88, 32'h44});
    // saturation of the narrow counter
    cyc(1, 0, 3'b000, rz, dz);
    repeat (20) cyc(0, 0, 3'b011, {5'd0, 5'd6, 5'd6}, {32'h0, 32'h66, 32'h61});
    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0][AW-1:0] rr;
      logic [2:0][DW-1:0] dd;
      for (int j = 0; j < 3; j++) begin
        rr[j] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
        dd[j] = $urandom;
      end
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
          3'($urandom), rr, dd);
    end
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
